// File: rtl/cpu_step_ctrl.sv
// Run/step/halt controller: gates the single-cycle core through cpu_en,
// debounces the step button and counts enabled cycles.
module cpu_step_ctrl #(
  parameter int unsigned DB_MAX  = 100000,
  parameter int unsigned RUN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt,
  output logic        cpu_en,
  output logic [31:0] cycle_cnt,
  output logic [1:0]  state_o
);

  localparam int unsigned DB_W  = 20;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 32;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_MAX - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t            state;
  logic              run_s1, run_s;
  logic              btn_s1, btn_s;
  logic              db_state, db_state_d;
  logic [DB_W-1:0]   db_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              step_pulse;

  // two-flop synchronisers for the asynchronous board inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_s1 <= 1'b0;
      run_s  <= 1'b0;
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      run_s1 <= run_sw;
      run_s  <= run_s1;
      btn_s1 <= step_btn;
      btn_s  <= btn_s1;
    end
  end

  // debounced level only follows btn_s after DB_MAX consecutive mismatches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_state   <= 1'b0;
      db_state_d <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_state_d <= db_state;
      if (btn_s == db_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_state <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign step_pulse = db_state & ~db_state_d;

  // run/step/halt FSM; div_cnt only advances while staying in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else begin
      div_cnt <= '0;
      case (state)
        IDLE: begin
          if (run_s)           state <= RUN;
          else if (step_pulse) state <= STEP;
        end
        RUN: begin
          if (halt)        state <= HALT;
          else if (!run_s) state <= IDLE;
          else             div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
        STEP:    state <= halt ? HALT : IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // halt masks the enable in the very cycle it is decoded
  assign cpu_en = ((state == STEP) | ((state == RUN) & (div_cnt == DIV_LAST))) & ~halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: two instances (RUN_DIV 1 and 3) share stimulus and
// are compared every cycle against a behavioural model of the controller.
module tb_cpu_step_ctrl;

  localparam int unsigned DBM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;
  logic        en1, en3;
  logic [31:0] cnt1, cnt3;
  logic [1:0]  st1, st3;

  int checks = 0;
  int errors = 0;

  cpu_step_ctrl #(.DB_MAX(DBM), .RUN_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .halt(halt),
    .cpu_en(en1), .cycle_cnt(cnt1), .state_o(st1)
  );

  cpu_step_ctrl #(.DB_MAX(DBM), .RUN_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .halt(halt),
    .cpu_en(en3), .cycle_cnt(cnt3), .state_o(st3)
  );

  always #5 clk = ~clk;

  wire [69:0] act_bus = {st1, en1, cnt1, st3, en3, cnt3};

  // ---------------- behavioural model ----------------
  logic [1:0]  m_st  [2];
  int unsigned m_rc  [2];   // 1-based index of the current RUN cycle
  logic [31:0] m_cnt [2];
  logic [31:0] cnt_off [2]; // offset applied after a counter deposit
  logic [1:0]  m_run, m_btn;
  logic        m_db, m_db_d;
  bit          m_hist[$];
  int unsigned edge_n;

  function automatic int unsigned div_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic m_en(int i);
    return !halt && (m_st[i] == 2'b10 ||
                     (m_st[i] == 2'b01 && (m_rc[i] % div_of(i)) == 0));
  endfunction

  function automatic logic [69:0] exp_bus();
    logic [31:0] c0, c1;
    c0 = m_cnt[0] + cnt_off[0];
    c1 = m_cnt[1] + cnt_off[1];
    return {m_st[0], m_en(0), c0, m_st[1], m_en(1), c1};
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_rc[i] = 0; m_cnt[i] = 0; end
    m_run = 0; m_btn = 0; m_db = 0; m_db_d = 0; edge_n = 0;
    forever begin
      bit pulse, flip;
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_rc[i] = 0; m_cnt[i] = 0; end
        m_run = 0; m_btn = 0; m_db = 0; m_db_d = 0;
        m_hist.delete();
      end else begin
        edge_n = edge_n + 1;
        pulse = m_db && !m_db_d;
        for (int i = 0; i < 2; i++) begin
          if (m_en(i)) m_cnt[i] = m_cnt[i] + 1;
          case (m_st[i])
            2'b00: if (m_run[1]) begin m_st[i] = 2'b01; m_rc[i] = 1; end
                   else if (pulse) m_st[i] = 2'b10;
            2'b01: if (halt) m_st[i] = 2'b11;
                   else if (!m_run[1]) m_st[i] = 2'b00;
                   else m_rc[i] = m_rc[i] + 1;
            2'b10: m_st[i] = halt ? 2'b11 : 2'b00;
            default: m_st[i] = 2'b11;
          endcase
        end
        // debounced level flips once the last DBM synchronised samples all disagree
        m_hist.push_back(m_btn[1]);
        if (m_hist.size() > DBM) void'(m_hist.pop_front());
        flip = (m_hist.size() == DBM);
        foreach (m_hist[j]) if (m_hist[j] == m_db) flip = 0;
        m_db_d = m_db;
        if (flip) m_db = !m_db;
        m_run = {m_run[0], run_sw};
        m_btn = {m_btn[0], step_btn};
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic r, input logic b, input logic h);
    @(negedge clk);
    run_sw = r; step_btn = b; halt = h;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run_sw = 0; step_btn = 0; halt = 0;
    rst = 1; cnt_off[0] = 0; cnt_off[1] = 0;
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if (act_bus !== 70'd0) begin
      errors++; $display("FAIL reset_values act=%h exp=0", act_bus);
    end
    checks++;
    if (act_bus !== exp_bus()) begin
      errors++; $display("FAIL reset_model act=%h exp=%h", act_bus, exp_bus());
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_step();
    int n_en, en_edge, step_cyc, k;
    logic b;
    n_en = 0; en_edge = -1; step_cyc = 0; k = 0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (i < 4)       b = (i % 2 == 0);
      else if (i < 16) b = 1'b1;
      else if (i < 20) b = (i % 2 == 1);
      else             b = 1'b0;
      cyc(1'b0, b, 1'b0);
      if (i == 4) k = int'(edge_n) + 1;
      checks++;
      if (act_bus !== exp_bus()) begin
        errors++; $display("FAIL step_cycle%0d act=%h exp=%h", i, act_bus, exp_bus());
      end
      if (en1) begin n_en++; en_edge = int'(edge_n); end
      if (st1 == 2'b10) step_cyc++;
    end
    checks++;
    if (n_en != 1) begin errors++; $display("FAIL step_pulses act=%0d exp=1", n_en); end
    checks++;
    if (en_edge != k + int'(DBM) + 2) begin
      errors++; $display("FAIL step_latency act=%0d exp=%0d", en_edge, k + int'(DBM) + 2);
    end
    checks++;
    if (cnt1 !== 32'd1) begin errors++; $display("FAIL step_count act=%0d exp=1", cnt1); end
    checks++;
    if (step_cyc != 1 || st1 !== 2'b00) begin
      errors++; $display("FAIL step_state cycles=%0d final=%b exp=1/00", step_cyc, st1);
    end
  endtask

  task automatic test_run_div();
    int n1, n3;
    n1 = 0; n3 = 0;
    do_reset();
    for (int i = 0; i < 35; i++) begin
      cyc(i < 30, 1'b0, 1'b0);
      checks++;
      if (act_bus !== exp_bus()) begin
        errors++; $display("FAIL rundiv_cycle%0d act=%h exp=%h", i, act_bus, exp_bus());
      end
      if (en1) n1++;
      if (en3) n3++;
    end
    checks++;
    if (n3 != 10 || cnt3 !== 32'd10) begin
      errors++; $display("FAIL rundiv3_count pulses=%0d cnt=%0d exp=10", n3, cnt3);
    end
    checks++;
    if (n1 != 30 || cnt1 !== 32'd30) begin
      errors++; $display("FAIL rundiv1_count pulses=%0d cnt=%0d exp=30", n1, cnt1);
    end
    checks++;
    if (st3 !== 2'b00 || st1 !== 2'b00) begin
      errors++; $display("FAIL rundiv_idle act=%b/%b exp=00", st1, st3);
    end
  endtask

  task automatic test_reset_mid_run();
    int guard;
    do_reset();
    guard = 0;
    while (m_cnt[0] != 5 && guard < 20) begin cyc(1'b1, 1'b0, 1'b0); guard++; end
    checks++;
    if (guard >= 20 || cnt1 !== 32'd5 || st1 !== 2'b01) begin
      errors++; $display("FAIL midrun_setup cnt=%0d st=%b exp=5/01", cnt1, st1);
    end
    @(posedge clk);
    #2;
    rst = 1; cnt_off[0] = 0; cnt_off[1] = 0;
    #1;
    checks++;
    if (en1 !== 1'b0 || st1 !== 2'b00 || cnt1 !== 32'd0) begin
      errors++; $display("FAIL midrun_async en=%b st=%b cnt=%0d exp=0/00/0", en1, st1, cnt1);
    end
    @(negedge clk);
    rst = 0;
    for (int e = 1; e <= 3; e++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (st1 !== ((e == 3) ? 2'b01 : 2'b00) || act_bus !== exp_bus()) begin
        errors++; $display("FAIL midrun_reentry edge%0d act=%h exp=%h", e, act_bus, exp_bus());
      end
    end
    checks++;
    if (en1 !== 1'b1) begin errors++; $display("FAIL midrun_first_en act=%b exp=1", en1); end
  endtask

  task automatic test_halt();
    int guard;
    logic [31:0] frozen;
    do_reset();
    guard = 0;
    while (m_st[0] != 2'b01 && guard < 20) begin cyc(1'b1, 1'b0, 1'b0); guard++; end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    checks++;
    if (guard >= 20 || en1 !== 1'b0 || act_bus !== exp_bus()) begin
      errors++; $display("FAIL halt_mask en=%b act=%h exp=%h", en1, act_bus, exp_bus());
    end
    frozen = m_cnt[0];
    cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (st1 !== 2'b11 || st3 !== 2'b11) begin
      errors++; $display("FAIL halt_enter act=%b/%b exp=11", st1, st3);
    end
    for (int i = 0; i < 24; i++) begin
      cyc((i / 6) % 2 == 1, i < 8, 1'b0);
      checks++;
      if (act_bus !== exp_bus() || en1 !== 1'b0 || en3 !== 1'b0) begin
        errors++; $display("FAIL halt_hold%0d act=%h exp=%h", i, act_bus, exp_bus());
      end
    end
    checks++;
    if (cnt1 !== frozen) begin errors++; $display("FAIL halt_frozen act=%0d exp=%0d", cnt1, frozen); end
    do_reset();
    #1;
    checks++;
    if (st1 !== 2'b00 || st3 !== 2'b00) begin
      errors++; $display("FAIL halt_release act=%b/%b exp=00", st1, st3);
    end
  endtask

  task automatic test_simultaneous();
    int seen_step;
    seen_step = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cyc(i >= 4, 1'b1, 1'b0);
      checks++;
      if (act_bus !== exp_bus()) begin
        errors++; $display("FAIL simul_cycle%0d act=%h exp=%h", i, act_bus, exp_bus());
      end
      if (st1 == 2'b10 || st3 == 2'b10) seen_step++;
    end
    checks++;
    if (seen_step != 0 || st1 !== 2'b01 || cnt1 !== 32'd7) begin
      errors++; $display("FAIL simul_run steps=%0d st=%b cnt=%0d exp=0/01/7", seen_step, st1, cnt1);
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    do_reset();
    @(negedge clk);
    force u_div1.cycle_cnt = 32'hFFFF_FFFE;
    force u_div3.cycle_cnt = 32'hFFFF_FFFE;
    cnt_off[0] = 32'hFFFF_FFFE - m_cnt[0];
    cnt_off[1] = 32'hFFFF_FFFE - m_cnt[1];
    #1;
    release u_div1.cycle_cnt;
    release u_div3.cycle_cnt;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(1'b0, i < 8, 1'b0);
        checks++;
        if (act_bus !== exp_bus()) begin
          errors++; $display("FAIL wrap_cycle%0d_%0d act=%h exp=%h", p, i, act_bus, exp_bus());
        end
      end
      want = (p == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      checks++;
      if (cnt1 !== want || cnt3 !== want) begin
        errors++; $display("FAIL wrap_step%0d act=%h/%h exp=%h", p, cnt1, cnt3, want);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic b, r;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      hold = 0; b = 1'b0; r = 1'b0;
      for (int c = 0; c < 100; c++) begin
        if (hold == 0) begin b = ~b; hold = int'($urandom_range(1, 10)); end
        hold--;
        if ($urandom_range(0, 15) == 0) r = ~r;
        cyc(r, b, $urandom_range(0, 39) == 0);
        checks++;
        if (act_bus !== exp_bus()) begin
          errors++; $display("FAIL random_r%0d_c%0d act=%h exp=%h", round, c, act_bus, exp_bus());
        end
      end
    end
  endtask

  initial begin
    cnt_off[0] = 0;
    cnt_off[1] = 0;
    test_reset();
    test_step();
    test_run_div();
    test_reset_mid_run();
    test_halt();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
